dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised, byte-addressed data memory for the RISC-V core with a valid/ready request channel and a valid/ready response channel. It supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) in little-endian order, with sign or zero extension on loads. Its access latency is configurable, and misaligned, out-of-range or illegal-size accesses are flagged on the response. It sits between the ALU address output and the write-back mux, and lets the core stall on memory.

## Interface
- ADDR_W, 10: byte-address width; memory depth is 2^ADDR_W bytes.
- LATENCY, 1: cycles from request acceptance to first `rsp_valid`; legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  RV32I funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  access rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch we/size/addr/wdata.
  - Go to RESP if LATENCY = 1; otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 1, the next edge enters RESP.
- Commit edge (the transition into RESP):
  - The access is checked. If it is legal, a store writes its bytes, or a load captures `rsp_rdata`.
  - `rsp_err` is registered on the same edge.
- RESP:
  - `rsp_valid` = 1, and `rsp_rdata` / `rsp_err` are held stable.
  - Remain in RESP while `rsp_ready` = 0.
  - On `rsp_valid && rsp_ready`, return to IDLE.
- Error conditions. Any of the following sets `rsp_err` = 1, suppresses the write, and forces `rsp_rdata` = 0:
  - `req_size` is 3, 6 or 7.
  - A store with `req_size` 4 or 5.
  - Halfword access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - Any of `addr[31:ADDR_W]` nonzero.
- Load extension:
  - B and H sign-extend from bit 7 and bit 15 respectively.
  - BU and HU zero-extend.
  - W returns `{m[a+3], m[a+2], m[a+1], m[a]}`.
- Stores write only the addressed bytes; all other bytes are untouched.
- Memory array:
  - Not reset; contents are X until written.
  - No initialisation ports; testbenches preload through hierarchical access.
- Only one transaction is in flight at a time; there is no pipelining.

## Timing
- Reset values:
  - state = IDLE, so `req_ready` = 1 from the first cycle after reset.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter = 0.
- While `rst` = 1, `req_valid` is ignored.
- `req_ready` is a combinational decode of state (IDLE); there is no combinational path from `req_valid`.
- Timing with `rsp_ready` held at 1:
  - A request accepted at edge T gives `rsp_valid` high in the cycle after edge T+LATENCY-1, i.e. for exactly one cycle.
  - `req_ready` returns high in the following cycle.
  - Peak throughput is one access per LATENCY+1 cycles.
- Backpressure: `rsp_valid`, `rsp_rdata` and `rsp_err` must not change while `rsp_valid && !rsp_ready`.
- Outside RESP, `rsp_rdata` and `rsp_err` keep their last values.
- Reset during WAIT: the transaction is dropped, no write occurs, and no response is issued.
- Reset during RESP: `rsp_valid` drops at the reset edge. The store has already committed and stays committed.
- A load immediately following a store to the same address returns the stored data, because the store commits before the load is accepted.

## Test plan
- LATENCY=1:
  - Stimulus: SW `0xDEADBEEF` @ `0x10`, then LW @ `0x10`.
  - Required: `rsp_rdata` = `0xDEADBEEF`, `rsp_err` = 0, and each response is high 1 cycle after acceptance.
- Byte and halfword extension:
  - Stimulus: SW `0x11223344` @ `0x20`, SB `0x80` @ `0x21`, then loads.
  - Required:
    - LB @ `0x21` → `0xFFFFFF80`; LBU @ `0x21` → `0x00000080`.
    - LH @ `0x20` → `0xFFFF8044`; LHU @ `0x20` → `0x00008044`.
    - LW @ `0x20` → `0x11228044`.
- Errors:
  - Stimulus: SH `0xBEEF` @ `0x23`, then SW @ `0x401` (ADDR_W=10), then LW with `req_size`=3 @ `0x0`; then LW @ `0x20`.
  - Required: each of the three returns `rsp_err` = 1 and `rsp_rdata` = 0; LW @ `0x20` still returns `0x11228044`.
- Backpressure:
  - Stimulus: LW with `rsp_ready` held low for 3 cycles.
  - Required:
    - `rsp_valid` stays high with stable data for 4 cycles.
    - `req_ready` stays low until the cycle after the handshake.
    - A `req_valid` asserted meanwhile is not accepted.
- LATENCY=3:
  - Stimulus: a request accepted at edge T.
  - Required: `rsp_valid` rises after edge T+2; `req_ready` is low for exactly 3 cycles with `rsp_ready`=1.
- Reset mid-WAIT (LATENCY=3):
  - Stimulus: SW `0xCAFEF00D` @ `0x40` over `0x0`; assert `rst` one cycle after acceptance; then LW @ `0x40`.
  - Required: no `rsp_valid`, and the LW returns `0x0`.

Source files
------------

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressed RV32I data memory with valid/ready request and response channels
module dmem_unit #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, next;
   logic [3:0] cnt;
   logic we_q;
   logic [2:0] size_q;
   logic [31:0] addr_q, wdata_q;
   logic [7:0] mem [2**ADDR_W];
   logic c_we;
   logic [2:0] c_size;
   logic [31:0] c_addr, c_wdata, load;
   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic commit, err;
   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   // with LATENCY=1 the commit edge is the acceptance edge, so the live request is used
   assign c_we    = req_ready ? req_we : we_q;
   assign c_size  = req_ready ? req_size : size_q;
   assign c_addr  = req_ready ? req_addr : addr_q;
   assign c_wdata = req_ready ? req_wdata : wdata_q;
   assign a0 = c_addr[ADDR_W-1:0];
   assign a1 = a0 + ADDR_W'(1);
   assign a2 = a0 + ADDR_W'(2);
   assign a3 = a0 + ADDR_W'(3);
   assign commit = !rst && next == RESP && state != RESP;
   always_comb begin
      next = state == IDLE ? (req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
           : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
           : (rsp_ready ? IDLE : RESP);
      err = c_size == 3'd3 || c_size > 3'd5 || (c_we && c_size[2])
         || (c_size[1:0] == 2'd1 && c_addr[0]) || (c_size == 3'd2 && c_addr[1:0] != 2'd0)
         || |c_addr[31:ADDR_W];
      load = c_size == 3'd0 ? {{24{mem[a0][7]}}, mem[a0]}
           : c_size == 3'd1 ? {{16{mem[a1][7]}}, mem[a1], mem[a0]}
           : c_size == 3'd2 ? {mem[a3], mem[a2], mem[a1], mem[a0]}
           : c_size == 3'd4 ? {24'd0, mem[a0]}
           : {16'd0, mem[a1], mem[a0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= next;
         if (req_valid && req_ready) begin
            cnt     <= 4'(LATENCY - 1);
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end else if (state == WAIT)
            cnt <= cnt - 4'd1;
         if (commit) begin
            rsp_err   <= err;
            rsp_rdata <= (err || c_we) ? 32'd0 : load;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (commit && !err && c_we) begin
         mem[a0] <= c_wdata[7:0];
         if (c_size[1:0] != 2'd0) mem[a1] <= c_wdata[15:8];
         if (c_size[1]) begin
            mem[a2] <= c_wdata[23:16];
            mem[a3] <= c_wdata[31:24];
         end
      end
   end
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: table-driven scoreboard bench for dmem_unit at LATENCY 1 and 3
module tb_dmem_unit;
   logic clk = 0;
   logic rst [2];
   logic req_valid [2];
   logic req_ready [2];
   logic rsp_valid [2];
   logic rsp_err [2];
   logic [31:0] rsp_rdata [2];
   logic req_we, rsp_ready;
   logic [2:0] req_size;
   logic [31:0] req_addr, req_wdata;
   int pass = 0, total = 0;
   typedef struct {
      int s;
      logic we;
      logic [2:0] size;
      logic [31:0] addr, wdata, rd;
      logic err;
   } vec_t;
   typedef struct {
      logic [31:0] rd;
      logic err;
   } exp_t;
   vec_t tab[$];
   exp_t sb[$];
   always #5 clk = ~clk;
   dmem_unit #(.ADDR_W(10), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
   dmem_unit #(.ADDR_W(10), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask
   task automatic xact(input vec_t t);
      int lat, low, l;
      logic seen;
      exp_t e;
      l = t.s == 0 ? 1 : 3;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready[t.s]), 1);
      req_we = t.we;
      req_size = t.size;
      req_addr = t.addr;
      req_wdata = t.wdata;
      rsp_ready = 1;
      req_valid[t.s] = 1;
      sb.push_back('{t.rd, t.err});
      @(posedge clk);
      #1 req_valid[t.s] = 0;
      lat = 0;
      low = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (!req_ready[t.s]) low++;
         seen = rsp_valid[t.s];
      end
      e = sb.pop_front();
      if (!seen) begin
         check("rsp_timeout", 0, 1);
         return;
      end
      check("latency", lat, l);
      check("rdata", rsp_rdata[t.s], e.rd);
      check("err", 32'(rsp_err[t.s]), 32'(e.err));
      @(negedge clk);
      check("rsp_valid_drop", 32'(rsp_valid[t.s]), 0);
      check("req_ready_back", 32'(req_ready[t.s]), 1);
      check("ready_low_cycles", low, l);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      exp_t e;
      logic seen;
      vec_t v;
      tab.push_back('{0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
      tab.push_back('{0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
      tab.push_back('{0, 1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1'b0});
      tab.push_back('{0, 1'b1, 3'd0, 32'h21, 32'h80, 32'h0, 1'b0});
      tab.push_back('{0, 1'b0, 3'd0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0});
      tab.push_back('{0, 1'b0, 3'd4, 32'h21, 32'h0, 32'h00000080, 1'b0});
      tab.push_back('{0, 1'b0, 3'd1, 32'h20, 32'h0, 32'hFFFF8044, 1'b0});
      tab.push_back('{0, 1'b0, 3'd5, 32'h20, 32'h0, 32'h00008044, 1'b0});
      tab.push_back('{0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h11228044, 1'b0});
      tab.push_back('{0, 1'b1, 3'd1, 32'h23, 32'hBEEF, 32'h0, 1'b1});
      tab.push_back('{0, 1'b1, 3'd2, 32'h401, 32'h12345678, 32'h0, 1'b1});
      tab.push_back('{0, 1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 1'b1});
      tab.push_back('{0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h11228044, 1'b0});
      tab.push_back('{0, 1'b1, 3'd1, 32'h22, 32'h1234A5B6, 32'h0, 1'b0});
      tab.push_back('{0, 1'b0, 3'd2, 32'h20, 32'h0, 32'hA5B68044, 1'b0});
      tab.push_back('{0, 1'b1, 3'd4, 32'h24, 32'h77, 32'h0, 1'b1});
      tab.push_back('{0, 1'b0, 3'd1, 32'h21, 32'h0, 32'h0, 1'b1});
      tab.push_back('{0, 1'b0, 3'd2, 32'h22, 32'h0, 32'h0, 1'b1});
      tab.push_back('{0, 1'b0, 3'd7, 32'h20, 32'h0, 32'h0, 1'b1});
      tab.push_back('{1, 1'b1, 3'd2, 32'h40, 32'h0, 32'h0, 1'b0});
      tab.push_back('{1, 1'b1, 3'd2, 32'h44, 32'h01020304, 32'h0, 1'b0});
      tab.push_back('{1, 1'b0, 3'd5, 32'h46, 32'h0, 32'h00000102, 1'b0});
      tab.push_back('{1, 1'b0, 3'd0, 32'h44, 32'h0, 32'h00000004, 1'b0});
      rst[0] = 1;
      rst[1] = 1;
      req_valid[0] = 0;
      req_valid[1] = 0;
      rsp_ready = 1;
      req_we = 0;
      req_size = 0;
      req_addr = 0;
      req_wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check("rst_req_ready", 32'(req_ready[s]), 1);
         check("rst_rsp_valid", 32'(rsp_valid[s]), 0);
         check("rst_rsp_rdata", rsp_rdata[s], 0);
         check("rst_rsp_err", 32'(rsp_err[s]), 0);
      end
      @(negedge clk);
      rst[0] = 0;
      rst[1] = 0;
      foreach (tab[i]) xact(tab[i]);
      // backpressure: hold the LW response for 3 cycles while a store tries to sneak in
      @(negedge clk);
      req_we = 0;
      req_size = 3'd2;
      req_addr = 32'h10;
      req_valid[0] = 1;
      rsp_ready = 0;
      sb.push_back('{32'hDEADBEEF, 1'b0});
      @(posedge clk);
      #1 req_valid[0] = 0;
      e = sb[0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid[0]), 1);
         check("bp_rdata", rsp_rdata[0], e.rd);
         check("bp_err", 32'(rsp_err[0]), 32'(e.err));
         check("bp_req_ready", 32'(req_ready[0]), 0);
         if (i == 0) begin
            req_we = 1;
            req_wdata = 32'h55555555;
            req_valid[0] = 1;
         end
         if (i == 3) begin
            req_valid[0] = 0;
            rsp_ready = 1;
         end
      end
      void'(sb.pop_front());
      @(negedge clk);
      check("bp_rsp_valid_after", 32'(rsp_valid[0]), 0);
      check("bp_req_ready_after", 32'(req_ready[0]), 1);
      v = '{0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
      xact(v);
      // reset one cycle after acceptance drops the store
      @(negedge clk);
      req_we = 1;
      req_size = 3'd2;
      req_addr = 32'h40;
      req_wdata = 32'hCAFEF00D;
      req_valid[1] = 1;
      @(posedge clk);
      #1 req_valid[1] = 0;
      @(negedge clk);
      rst[1] = 1;
      @(negedge clk);
      rst[1] = 0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | rsp_valid[1];
      end
      check("rst_wait_no_rsp", 32'(seen), 0);
      v = '{1, 1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 1'b0};
      xact(v);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
